// File: rtl/j_serial_adder_pkg.sv
// Shared definitions for the serial adder slice.
// FSM state encodings and a counter-sizing helper.
package j_serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ceiling log2, used to size the digit counter.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/j_digit_adder.sv
// DIGIT-bit ripple-carry adder built from jfulladder cells.
// Ports: a_d, b_d, cin -> s_d, cout, c_msb (carry into top bit).
module j_digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        jfulladder u_fa (
            .a    (a_d[i]),
            .b    (b_d[i]),
            .cin  (c[i]),
            .s    (s_d[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/jfulladder.sv
// Single-bit full adder, the ripple cell of the digit adder.
// Ports: a, b, cin -> s, cout.
module jfulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/j_serial_adder.sv
// Multi-cycle adder/subtractor, DIGIT bits per clock, start/done handshake.
// Ports: clk, rst_n, start, a, b, carry_in, sub -> busy, done, sum, carry_out, overflow.
module j_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    import j_serial_adder_pkg::*;

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = clog2(K) + 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("j_serial_adder: WIDTH must be >= 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("j_serial_adder: DIGIT must divide WIDTH");
    end

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             c;

    logic [DIGIT-1:0] s_d;
    logic             d_cout;
    logic             d_cmsb;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] acc_nxt;

    j_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d   (a_sh[DIGIT-1:0]),
        .b_d   (b_sh[DIGIT-1:0]),
        .cin   (c),
        .s_d   (s_d),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

    // start is only honoured between operations.
    assign accept = start && (state == ST_IDLE || state == ST_DONE);
    assign last   = (cnt == CW'(K - 1));

    // New digit enters at the top; after K digits the word is aligned.
    assign acc_nxt = WIDTH'({s_d, acc} >> DIGIT);

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            c         <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                state <= ST_RUN;
                cnt   <= '0;
                a_sh  <= a;
                // Subtraction as a + ~b + ~borrow.
                b_sh  <= sub ? ~b : b;
                c     <= sub ? ~carry_in : carry_in;
                acc   <= '0;
            end else begin
                case (state)
                    ST_RUN: begin
                        a_sh <= a_sh >> DIGIT;
                        b_sh <= b_sh >> DIGIT;
                        acc  <= acc_nxt;
                        c    <= d_cout;
                        cnt  <= cnt + 1'b1;
                        if (last) begin
                            state     <= ST_DONE;
                            sum       <= acc_nxt;
                            carry_out <= d_cout;
                            overflow  <= d_cmsb ^ d_cout;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    ST_IDLE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_j_serial_adder.sv
// Directed bench for j_serial_adder, WIDTH=8 with DIGIT=1 and DIGIT=4.
// Ports driven: shared operands, separate start per instance.
module tb_j_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start1;
    logic       start4;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_in;
    logic       sub;

    logic       busy1, done1, co1, ov1;
    logic [7:0] sum1;
    logic       busy4, done4, co4, ov4;
    logic [7:0] sum4;

    int checks = 0;
    int errors = 0;

    j_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .carry_out (co1),
        .overflow  (ov1)
    );

    j_serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start4),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .busy      (busy4),
        .done      (done4),
        .sum       (sum4),
        .carry_out (co4),
        .overflow  (ov4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input int d);
        return (d == 1) ? done1 : done4;
    endfunction

    task automatic run_op(input int d, input logic [7:0] ta,
                          input logic [7:0] tbv, input logic tc,
                          input logic ts, input logic [7:0] es,
                          input logic eco, input logic eov,
                          input string tag);
        int n;
        int k;
        k = (d == 1) ? 8 : 2;
        @(negedge clk);
        a        = ta;
        b        = tbv;
        carry_in = tc;
        sub      = ts;
        if (d == 1) start1 = 1'b1;
        else        start4 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        n = 1;
        while (done_of(d) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, k + 1);
        if (d == 1) begin
            chk({tag, "_sum"}, {24'd0, sum1}, {24'd0, es});
            chk({tag, "_co"}, {31'd0, co1}, {31'd0, eco});
            chk({tag, "_ov"}, {31'd0, ov1}, {31'd0, eov});
        end else begin
            chk({tag, "_sum"}, {24'd0, sum4}, {24'd0, es});
            chk({tag, "_co"}, {31'd0, co4}, {31'd0, eco});
            chk({tag, "_ov"}, {31'd0, ov4}, {31'd0, eov});
        end
        @(negedge clk);
        chk({tag, "_done_1cyc"}, {31'd0, done_of(d)}, 32'd0);
    endtask

    initial begin
        int t;
        int t1;
        int t2;
        int nd;
        rst_n    = 1'b0;
        start1   = 1'b0;
        start4   = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        carry_in = 1'b0;
        sub      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy1", {31'd0, busy1}, 32'd0);
        chk("rst_done1", {31'd0, done1}, 32'd0);
        chk("rst_sum1", {24'd0, sum1}, 32'd0);
        chk("rst_co1", {31'd0, co1}, 32'd0);
        chk("rst_ov1", {31'd0, ov1}, 32'd0);
        chk("rst_busy4", {31'd0, busy4}, 32'd0);
        chk("rst_done4", {31'd0, done4}, 32'd0);
        chk("rst_sum4", {24'd0, sum4}, 32'd0);
        chk("rst_co4", {31'd0, co4}, 32'd0);
        chk("rst_ov4", {31'd0, ov4}, 32'd0);

        // Add, carry wrap, subtract on both digit sizes
        run_op(1, 8'h3C, 8'h51, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, "add_d1");
        run_op(4, 8'h3C, 8'h51, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, "add_d4");
        run_op(1, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, "wrap_d1");
        run_op(4, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, "wrap_d4");
        run_op(1, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_d1");
        run_op(4, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_d4");

        // start pulsed mid-RUN is ignored; operand change has no effect
        @(negedge clk);
        a = 8'h3C; b = 8'h51; carry_in = 1'b0; sub = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'h01; carry_in = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (done1 === 1'b1) nd++;
            @(negedge clk);
        end
        chk("midrun_ndone", nd, 1);
        chk("midrun_sum", {24'd0, sum1}, 32'h8D);
        chk("midrun_idle", {31'd0, busy1}, 32'd0);

        // start held through DONE: back-to-back ops without IDLE
        a = 8'h10; b = 8'h20; carry_in = 1'b0; sub = 1'b1;
        start1 = 1'b1;
        t = 0;
        t1 = -1;
        while (t < 40 && t1 < 0) begin
            @(negedge clk);
            t++;
            if (done1 === 1'b1) t1 = t;
        end
        chk("b2b_first_done", {31'd0, done1}, 32'd1);
        chk("b2b_first_sum", {24'd0, sum1}, 32'hF0);
        a = 8'h7F; b = 8'h01; sub = 1'b0;
        @(negedge clk);
        t++;
        start1 = 1'b0;
        chk("b2b_rerun_busy", {31'd0, busy1}, 32'd1);
        chk("b2b_sum_held", {24'd0, sum1}, 32'hF0);
        t2 = -1;
        while (t < 80 && t2 < 0) begin
            @(negedge clk);
            t++;
            if (done1 === 1'b1) t2 = t;
        end
        chk("b2b_spacing", t2 - t1, 9);
        chk("b2b_second_sum", {24'd0, sum1}, 32'h80);
        chk("b2b_second_ov", {31'd0, ov1}, 32'd1);
        @(negedge clk);

        // Abort mid-RUN with reset
        a = 8'h3C; b = 8'h51; carry_in = 1'b0; sub = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_pre_busy", {31'd0, busy1}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        chk("abort_done", {31'd0, done1}, 32'd0);
        chk("abort_sum", {24'd0, sum1}, 32'd0);
        chk("abort_sum4", {24'd0, sum4}, 32'd0);
        nd = 0;
        repeat (2) begin
            @(negedge clk);
            if (done1 === 1'b1) nd++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done1 === 1'b1) nd++;
        end
        chk("abort_no_done", nd, 0);
        run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "post_d1");
        run_op(4, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "post_d4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
